mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Load/store unit in the MEM stage of the 5-stage RV32I pipeline.
- Takes the M-stage control, address (ALUResultM) and store data, and runs a req/ready handshake with the data memory.
- Produces the aligned, sign- or zero-extended ReadData that the MEM/WB pipeline register captures.
- Stalls the pipeline while the memory access is outstanding, and flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT_CYC, 16: maximum number of cycles in REQ without mem_ready before the access is aborted; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- MemReadM  input  1  load in MEM stage
- MemWriteM  input  1  store in MEM stage
- Funct3M  input  3  access size/sign (RV32I load/store funct3)
- ALUResultM  input  32  byte address
- WriteDataM  input  32  store data (rs2)
- ReadData  output  32  extended load data to MEM/WB
- StallM  output  1  freeze IF..MEM and hold MEM/WB
- ErrM  output  1  misaligned, illegal or timed-out access
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  1 = write
- mem_addr  output  32  word address ({addr[31:2],2'b00})
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte enables (0 for reads)
- mem_ready  input  1  memory accepts the write / returns rdata this cycle
- mem_rdata  input  32  read word, valid when mem_ready=1

Behaviour:
- Reset is synchronous on clk, active-low on rst_n. When rst_n=0 at a posedge:
  - state goes to IDLE;
  - mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, the ReadData register, the ErrM register and the timeout counter all go to 0.
  - Reset mid-REQ abandons the transaction; mem_req=0 on the next cycle.
- States: IDLE, REQ, DONE.
- access = MemReadM | MemWriteM.
- bad = any of:
  - MemReadM & MemWriteM;
  - Funct3M in {011,110,111};
  - Funct3M in {100,101} with MemWriteM;
  - halfword with addr[0] != 0;
  - word with addr[1:0] != 0.
- IDLE:
  - access & !bad: StallM=1 (combinational). Latch mem_addr/mem_we/mem_wdata/mem_wstrb, lane and Funct3, set mem_req=1, go to REQ.
  - access & bad: ErrM=1 (combinational), StallM=0, ReadData=0, no request, stay in IDLE.
  - no access: StallM=0, ReadData=0, ErrM=0.
- REQ:
  - StallM=1. mem_req and all request fields are held stable.
  - mem_ready=1: mem_req goes to 0, load data is extracted and registered, go to DONE.
  - Counter counts cycles spent in REQ. If TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC without mem_ready: drop mem_req, set the ErrM register, ReadData=0, go to DONE.
- DONE:
  - StallM=0. ReadData and ErrM come from registers. The pipeline advances at this edge.
  - M-stage inputs are ignored in this cycle (they still belong to the completing instruction). Go to IDLE; ErrM is cleared.
- Timing: minimum MEM occupancy is 3 cycles (IDLE-stall, REQ, DONE); each extra cycle of mem_ready wait adds 1.
- Load extraction, with lane = addr[1:0]:
  - LB: sign-extend rdata[8*lane+7:8*lane].
  - LBU: zero-extend the same byte.
  - LH/LHU: halfword at lane[1], sign- or zero-extended.
  - LW: whole word.
- Store formatting:
  - SB: wdata={4{WriteDataM[7:0]}}, wstrb=4'b0001<<lane.
  - SH: wdata={2{WriteDataM[15:0]}}, wstrb=4'b0011<<lane.
  - SW: wdata=WriteDataM, wstrb=4'b1111.
- Store completion: ReadData=0 in DONE.
- Write-back: x0 is not special here (handled in WB).

Test Plan:
- LW addr 0x100, mem_ready on the first REQ cycle, rdata=0xDEADBEEF -> StallM high for 2 cycles, mem_addr=0x100, mem_wstrb=0; DONE: ReadData=0xDEADBEEF, StallM=0, ErrM=0.
- LB at 0x103 and LBU at 0x103, rdata=0x80FF7F01 -> ReadData=0xFFFFFF80 and 0x00000080 respectively; LH at 0x102 -> 0xFFFF80FF.
- SB addr 0x205, WriteDataM=0x123456AB -> mem_we=1, mem_addr=0x204, mem_wdata=0xABABABAB, mem_wstrb=0010; SH 0x206 -> wstrb=1100.
- LW addr 0x102 -> ErrM=1 same cycle, StallM=0, mem_req never asserted; SH at 0x001 -> ErrM=1; MemReadM=MemWriteM=1 -> ErrM=1.
- TIMEOUT_CYC=4, mem_ready held 0 -> mem_req high for exactly 4 cycles, then DONE with ErrM=1, ReadData=0, StallM released.
- rst_n low during REQ with 3 wait cycles outstanding -> next cycle mem_req=0, StallM=0, all outputs 0; a following LW completes normally.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: req/ready data-memory bus between the MEM-stage LSU and data memory.
interface mem_stage_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_ready, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I MEM-stage load/store unit with req/ready memory handshake,
// load extension, store lane formatting, pipeline stall and access-error reporting.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   MemReadM,
  input  logic                   MemWriteM,
  input  logic [2:0]             Funct3M,
  input  logic [31:0]            ALUResultM,
  input  logic [31:0]            WriteDataM,
  output logic [31:0]            ReadData,
  output logic                   StallM,
  output logic                   ErrM,
  mem_stage_lsu_if.master        mem
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d, cnt_q, cnt_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  f3_q, f3_d;
  logic        access, bad, timeout;
  logic [1:0]  lane;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load;
  assign lane    = ALUResultM[1:0];
  assign access  = MemReadM | MemWriteM;
  assign bad     = (MemReadM & MemWriteM) | (Funct3M[1:0] == 2'b11) | (Funct3M == 3'b110) |
                   (Funct3M[2] & MemWriteM) | (Funct3M[1:0] == 2'b01 & lane[0]) |
                   (Funct3M[1:0] == 2'b10 & lane != 2'b00);
  assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == TIMEOUT_CYC - 1);
  // Funct3 bit2 selects zero-extension, bit1 word, bit0 halfword.
  assign rbyte   = mem.mem_rdata[{lane_q, 3'b000} +: 8];
  assign rhalf   = mem.mem_rdata[{lane_q[1], 4'b0000} +: 16];
  assign load    = f3_q[1] ? mem.mem_rdata :
                   f3_q[0] ? {{16{~f3_q[2] & rhalf[15]}}, rhalf} :
                             {{24{~f3_q[2] & rbyte[7]}}, rbyte};
  assign StallM   = (state_q == REQ) || (state_q == IDLE && access && !bad);
  assign ErrM     = (state_q == IDLE) ? access & bad : (state_q == DONE) && err_q;
  assign ReadData = (state_q == DONE) ? rd_q : '0;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    lane_d  = lane_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        rd_d  = '0;
        cnt_d = '0;
        if (access && !bad) begin
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = {ALUResultM[31:2], 2'b00};
          wdata_d = Funct3M[1] ? WriteDataM : Funct3M[0] ? {2{WriteDataM[15:0]}} : {4{WriteDataM[7:0]}};
          wstrb_d = !MemWriteM ? 4'b0000 : Funct3M[1] ? 4'b1111 : (Funct3M[0] ? 4'b0011 : 4'b0001) << lane;
          lane_d  = lane;
          f3_d    = Funct3M;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem.mem_ready) begin
          req_d   = 1'b0;
          rd_d    = we_q ? '0 : load;
          state_d = DONE;
        end else if (timeout) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          rd_d    = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1;
        end
      end
      default: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      lane_q  <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      lane_q  <= lane_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu with a latency-programmable memory
// responder and a behavioural load/store reference model.
module tb_mem_stage_lsu;
  localparam int TO = 4;
  typedef struct {
    logic        err;
    logic [31:0] rd;
  } out_t;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          reqc;
  } bus_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [2:0]  Funct3M = '0;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic [31:0] ReadData;
  logic        StallM, ErrM;
  int          checks = 0, failures = 0;
  out_t        oq[$];
  bus_t        bq[$];
  bit          mon_en = 1'b0;
  int          cur_lat = 0;
  logic [31:0] cur_rdata = '0;
  mem_stage_lsu_if mem();
  mem_stage_lsu #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadData(ReadData), .StallM(StallM),
    .ErrM(ErrM), .mem(mem)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [1:0] l, input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * l)) & 32'hff;
    h = (w >> (16 * (l / 2))) & 32'hffff;
    case (f3)
      3'd0:    return b >= 128 ? b - 256 : b;
      3'd1:    return h >= 32768 ? h - 65536 : h;
      3'd2:    return w;
      3'd4:    return b;
      default: return h;
    endcase
  endfunction
  // Memory responder: asserts ready after cur_lat wait cycles of an outstanding request.
  initial begin
    int wcnt;
    wcnt = 0;
    mem.mem_ready = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem.mem_req) begin
        if (wcnt == cur_lat) begin
          mem.mem_ready = 1'b1;
          mem.mem_rdata = cur_rdata;
        end else begin
          mem.mem_ready = 1'b0;
          mem.mem_rdata = $urandom;
          wcnt++;
        end
      end else begin
        mem.mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end
  // Monitor: pops the scoreboard on every pipeline advance and on every new memory request.
  initial begin
    bit   prev_req;
    int   reqc;
    out_t o;
    bus_t be;
    prev_req = 1'b0;
    reqc = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!StallM) begin
          chk("advance_expected", 32'(oq.size() > 0), 32'd1);
          if (oq.size() > 0) begin
            o = oq.pop_front();
            chk("ReadData", ReadData, o.rd);
            chk("ErrM", 32'(ErrM), 32'(o.err));
          end
        end
        if (mem.mem_req && !prev_req) begin
          chk("req_expected", 32'(bq.size() > 0), 32'd1);
          if (bq.size() > 0) begin
            be = bq.pop_front();
            chk("mem_addr", mem.mem_addr, be.addr);
            chk("mem_we", 32'(mem.mem_we), 32'(be.we));
            chk("mem_wstrb", 32'(mem.mem_wstrb), 32'(be.wstrb));
            if (be.we) chk("mem_wdata", mem.mem_wdata, be.wdata);
          end
          reqc = 1;
        end else if (mem.mem_req) begin
          reqc++;
        end else if (prev_req) begin
          chk("req_cycles", reqc, be.reqc);
        end
      end
      prev_req = mem.mem_req;
    end
  end
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input logic [31:0] rw);
    bit   acc, b, adv;
    int   exp_cyc, cyc, sz;
    out_t o;
    bus_t e;
    acc = rd || wr;
    b = (rd && wr) || f3 == 3 || f3 == 6 || f3 == 7 || (wr && (f3 == 4 || f3 == 5)) ||
        ((f3 == 1 || f3 == 5) && a[0]) || (f3 == 2 && a[1:0] != 0);
    cur_lat = lat;
    cur_rdata = rw;
    o.err = 1'b0;
    o.rd = '0;
    exp_cyc = 1;
    if (acc && b) begin
      o.err = 1'b1;
    end else if (acc) begin
      e.reqc = (lat + 1 > TO) ? TO : lat + 1;
      exp_cyc = e.reqc + 2;
      o.err = (lat + 1 > TO);
      o.rd = (wr || o.err) ? 32'd0 : load_ref(f3, a[1:0], rw);
      sz = 1 << (f3 % 4);
      e.addr = a & ~32'd3;
      e.we = wr;
      e.wdata = sz == 1 ? (wd & 32'hff) * 32'h01010101 : sz == 2 ? (wd & 32'hffff) * 32'h00010001 : wd;
      e.wstrb = !wr ? 4'd0 : 4'(((1 << sz) - 1) << a[1:0]);
      bq.push_back(e);
    end
    oq.push_back(o);
    MemReadM = rd;
    MemWriteM = wr;
    Funct3M = f3;
    ALUResultM = a;
    WriteDataM = wd;
    cyc = 0;
    adv = 1'b0;
    while (!adv && cyc < 20) begin
      @(negedge clk);
      cyc++;
      adv = !StallM;
      @(posedge clk);
      #1;
    end
    chk("mem_occupancy", cyc, exp_cyc);
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_mem_req", 32'(mem.mem_req), 32'd0);
    chk("rst_StallM", 32'(StallM), 32'd0);
    chk("rst_ReadData", ReadData, 32'd0);
    chk("rst_ErrM", 32'(ErrM), 32'd0);
    chk("rst_mem_addr", mem.mem_addr, 32'd0);
    chk("rst_mem_wstrb", 32'(mem.mem_wstrb), 32'd0);
    mon_en = 1'b1;
    issue(1, 0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    issue(1, 0, 3'd0, 32'h103, 32'h0, 0, 32'h80FF7F01);
    issue(1, 0, 3'd4, 32'h103, 32'h0, 1, 32'h80FF7F01);
    issue(1, 0, 3'd1, 32'h102, 32'h0, 2, 32'h80FF7F01);
    issue(0, 1, 3'd0, 32'h205, 32'h123456AB, 0, 32'h0);
    issue(0, 1, 3'd1, 32'h206, 32'h123456AB, 1, 32'h0);
    issue(0, 1, 3'd2, 32'h208, 32'hCAFEF00D, 0, 32'h0);
    issue(1, 0, 3'd2, 32'h102, 32'h0, 0, 32'h0);
    issue(0, 1, 3'd1, 32'h001, 32'h0, 0, 32'h0);
    issue(1, 1, 3'd2, 32'h100, 32'h0, 0, 32'h0);
    issue(0, 0, 3'd2, 32'h100, 32'h0, 0, 32'h0);
    issue(1, 0, 3'd2, 32'h400, 32'h0, 6, 32'h11111111);
    issue(1, 0, 3'd2, 32'h404, 32'h0, 3, 32'h22222222);
    mon_en = 1'b0;
    cur_lat = 3;
    MemReadM = 1'b1;
    Funct3M = 3'd2;
    ALUResultM = 32'h300;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    MemReadM = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_mem_req", 32'(mem.mem_req), 32'd0);
    chk("midrst_StallM", 32'(StallM), 32'd0);
    chk("midrst_ReadData", ReadData, 32'd0);
    chk("midrst_ErrM", 32'(ErrM), 32'd0);
    chk("midrst_mem_addr", mem.mem_addr, 32'd0);
    chk("midrst_mem_we", 32'(mem.mem_we), 32'd0);
    chk("midrst_mem_wdata", mem.mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    oq.delete();
    bq.delete();
    mon_en = 1'b1;
    issue(1, 0, 3'd2, 32'h500, 32'h0, 1, 32'hA5A55A5A);
    for (int i = 0; i < 200; i++) begin
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      int          k;
      k = $urandom_range(0, 9);
      rd = (k <= 3) || (k == 7);
      wr = (k >= 4 && k <= 7);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (wr) f3 = 3'($urandom_range(0, 2));
      else begin
        k = $urandom_range(0, 4);
        f3 = k < 3 ? 3'(k) : 3'(k + 1);
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << (f3 % 4)) - 32'd1);
      issue(rd, wr, f3, a, $urandom, $urandom_range(0, 5), $urandom);
    end
    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(oq.size() + bq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
